passcode_keypad_capture: RTL and testbench

//  Front-end stage feeding the ATM secure-room FSM's passcode_digit_1/passcode_digit_2 inputs.

---
 rtl/atm_pkg.sv | 24 ++
 rtl/passcode_keypad_capture_if.sv | 43 ++++
 rtl/key_debouncer.sv | 51 +++++
 rtl/passcode_keypad_capture.sv | 146 ++++++++++++++
 tb/tb_passcode_keypad_capture.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/atm_pkg.sv
// Definitions shared between the keypad capture front-end and the ATM secure-room FSM.
// Holds the capture state encoding and the digit constants both sides agree on.
package atm_pkg;

    localparam int DIGIT_W = 2;

    typedef logic [DIGIT_W-1:0] digit_t;

    localparam digit_t CODE_CLEARED = 2'b00;
    localparam digit_t CODE_DIGIT_A = 2'b01;
    localparam digit_t CODE_DIGIT_B = 2'b10;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_ONE     = 2'd1,
        ST_PRESENT = 2'd2
    } entry_state_t;

    // True when a digit matches one of the codes the room FSM treats as meaningful.
    function automatic logic is_valid_digit(digit_t d);
        return (d == CODE_DIGIT_A) || (d == CODE_DIGIT_B);
    endfunction

endpackage

// File: rtl/passcode_keypad_capture_if.sv
// Keypad-side inputs and room-FSM-side outputs of the passcode capture stage.
// The master drives keypad signals and observes results; the capture block is the slave.
interface passcode_keypad_capture_if;
    import atm_pkg::*;

    // Keypad side: key_press_raw is a level, key_code is only meaningful while it is high,
    // clear_key is a single-cycle synchronous abort. There is no back-pressure anywhere.
    logic         key_press_raw;
    digit_t       key_code;
    logic         clear_key;

    logic         [1:0] digit_count;
    digit_t       passcode_digit_1;
    digit_t       passcode_digit_2;
    logic         code_ready;
    logic         entry_timeout;
    entry_state_t fsm_state;

    modport master (
        output key_press_raw,
        output key_code,
        output clear_key,
        input  passcode_digit_1,
        input  passcode_digit_2,
        input  code_ready,
        input  entry_timeout,
        input  digit_count,
        input  fsm_state
    );

    modport slave (
        input  key_press_raw,
        input  key_code,
        input  clear_key,
        output passcode_digit_1,
        output passcode_digit_2,
        output code_ready,
        output entry_timeout,
        output digit_count,
        output fsm_state
    );

endinterface

// File: rtl/key_debouncer.sv
// Two-flop synchroniser plus stable-count debouncer for the raw keypad strobe.
// Emits one registered press_evt pulse per accepted press; releases are tracked silently.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_press_raw,
    output logic press_evt
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic             key_level;
    logic [CNT_W-1:0] stable_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= key_press_raw;
            sync_2 <= sync_1;
        end
    end

    // key_level flips only after DEBOUNCE_CYCLES consecutive synced samples disagree with it;
    // any sample that agrees restarts the run.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_level  <= 1'b0;
            stable_cnt <= '0;
            press_evt  <= 1'b0;
        end else begin
            press_evt <= 1'b0;
            if (sync_2 == key_level) begin
                stable_cnt <= '0;
            end else if (stable_cnt >= CNT_LAST) begin
                key_level  <= sync_2;
                stable_cnt <= '0;
                press_evt  <= sync_2;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/passcode_keypad_capture.sv
// Captures two debounced keypad digits and presents them as a stable pair to the room FSM,
// driving 2'b00/2'b00 whenever an entry is incomplete, timed out or aborted.
module passcode_keypad_capture
    import atm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1000,
    parameter int HOLD_CYCLES     = 8
) (
    input  logic clk,
    input  logic reset_n,
    passcode_keypad_capture_if.slave kp
);

    localparam int                TO_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam int                HOLD_W    = $clog2(HOLD_CYCLES + 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    logic press_evt;

    entry_state_t      state, state_n;
    digit_t            d1_q, d1_n;
    logic [TO_W-1:0]   to_cnt, to_cnt_n;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_n;

    digit_t     digit1_q, digit1_n;
    digit_t     digit2_q, digit2_n;
    logic       ready_q, ready_n;
    logic       timeout_q, timeout_n;
    logic [1:0] count_q, count_n;

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk          (clk),
        .reset_n      (reset_n),
        .key_press_raw(kp.key_press_raw),
        .press_evt    (press_evt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_EMPTY;
            d1_q      <= CODE_CLEARED;
            to_cnt    <= '0;
            hold_cnt  <= '0;
            digit1_q  <= CODE_CLEARED;
            digit2_q  <= CODE_CLEARED;
            ready_q   <= 1'b0;
            timeout_q <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            state     <= state_n;
            d1_q      <= d1_n;
            to_cnt    <= to_cnt_n;
            hold_cnt  <= hold_cnt_n;
            digit1_q  <= digit1_n;
            digit2_q  <= digit2_n;
            ready_q   <= ready_n;
            timeout_q <= timeout_n;
            count_q   <= count_n;
        end
    end

    // Outputs are computed as next-register values so nothing combinational reaches the ports.
    // Default is the cleared presentation; each state re-asserts what it must keep showing.
    always_comb begin
        state_n    = state;
        d1_n       = d1_q;
        to_cnt_n   = to_cnt;
        hold_cnt_n = hold_cnt;
        digit1_n   = CODE_CLEARED;
        digit2_n   = CODE_CLEARED;
        ready_n    = 1'b0;
        timeout_n  = 1'b0;
        count_n    = 2'd0;

        if (kp.clear_key) begin
            state_n    = ST_EMPTY;
            d1_n       = CODE_CLEARED;
            to_cnt_n   = '0;
            hold_cnt_n = '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (press_evt) begin
                        state_n  = ST_ONE;
                        d1_n     = kp.key_code;
                        to_cnt_n = '0;
                        count_n  = 2'd1;
                    end
                end

                ST_ONE: begin
                    count_n = 2'd1;
                    // A press in the final timeout cycle still completes the entry.
                    if (press_evt) begin
                        state_n    = ST_PRESENT;
                        digit1_n   = d1_q;
                        digit2_n   = kp.key_code;
                        ready_n    = 1'b1;
                        count_n    = 2'd2;
                        hold_cnt_n = HOLD_ONE;
                        to_cnt_n   = '0;
                    end else if (to_cnt >= TO_LAST) begin
                        state_n   = ST_EMPTY;
                        d1_n      = CODE_CLEARED;
                        timeout_n = 1'b1;
                        count_n   = 2'd0;
                        to_cnt_n  = '0;
                    end else begin
                        to_cnt_n = to_cnt + 1'b1;
                    end
                end

                ST_PRESENT: begin
                    // hold_cnt counts presented cycles, starting at 1 on the entry edge.
                    if (hold_cnt >= HOLD_LAST) begin
                        state_n    = ST_EMPTY;
                        d1_n       = CODE_CLEARED;
                        hold_cnt_n = '0;
                    end else begin
                        hold_cnt_n = hold_cnt + 1'b1;
                        digit1_n   = digit1_q;
                        digit2_n   = digit2_q;
                        count_n    = 2'd2;
                    end
                end

                default: begin
                    state_n = ST_EMPTY;
                end
            endcase
        end
    end

    assign kp.passcode_digit_1 = digit1_q;
    assign kp.passcode_digit_2 = digit2_q;
    assign kp.code_ready       = ready_q;
    assign kp.entry_timeout    = timeout_q;
    assign kp.digit_count      = count_q;
    assign kp.fsm_state        = state;

endmodule

// File: tb/tb_passcode_keypad_capture.sv
// Bench for passcode_keypad_capture: directed scenarios plus randomized keypad activity,
// checked every cycle against a queue-based behavioural model of the capture rules.
module tb_passcode_keypad_capture;
    import atm_pkg::*;

    localparam int DEB  = 4;
    localparam int TMO  = 20;
    localparam int HOLD = 8;

    // ---------------- clock / reset ----------------
    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    passcode_keypad_capture_if kp();

    passcode_keypad_capture #(
        .DEBOUNCE_CYCLES(DEB),
        .TIMEOUT_CYCLES (TMO),
        .HOLD_CYCLES    (HOLD)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .kp     (kp)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic       raw_hist[$];   // raw samples, newest first
    logic       deb_level;
    logic       pe_prev;       // press accepted at the previous edge
    digit_t     m_digits[$];
    int         m_age;
    int         m_left;
    digit_t     exp_d1, exp_d2;
    logic       exp_ready, exp_to;
    logic [1:0] exp_cnt;
    logic [3:0] exp_q[$];

    task automatic model_reset();
        raw_hist.delete();
        for (int i = 0; i < 2 + DEB; i++) raw_hist.push_front(1'b0);
        deb_level = 1'b0;
        pe_prev   = 1'b0;
        m_digits.delete();
        m_age     = 0;
        m_left    = 0;
        exp_d1    = 2'b00;
        exp_d2    = 2'b00;
        exp_ready = 1'b0;
        exp_to    = 1'b0;
        exp_cnt   = 2'd0;
        exp_q.delete();
    endtask

    task automatic model_step();
        logic all_diff;
        logic pe_now;
        exp_ready = 1'b0;
        exp_to    = 1'b0;
        if (kp.clear_key) begin
            m_digits.delete();
            m_left  = 0;
            exp_d1  = 2'b00;
            exp_d2  = 2'b00;
            exp_cnt = 2'd0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_digits.delete();
                exp_d1  = 2'b00;
                exp_d2  = 2'b00;
                exp_cnt = 2'd0;
            end
        end else if (m_digits.size() == 1) begin
            if (pe_prev) begin
                m_digits.push_back(kp.key_code);
                exp_d1    = m_digits[0];
                exp_d2    = m_digits[1];
                exp_ready = 1'b1;
                exp_cnt   = 2'd2;
                m_left    = HOLD;
                exp_q.push_back({m_digits[0], m_digits[1]});
            end else begin
                m_age++;
                if (m_age == TMO) begin
                    m_digits.delete();
                    exp_to  = 1'b1;
                    exp_cnt = 2'd0;
                end
            end
        end else if (pe_prev) begin
            m_digits.push_back(kp.key_code);
            m_age   = 0;
            exp_cnt = 2'd1;
        end
        // Synced view lags raw by two edges; accept when the last DEB synced samples all disagree.
        raw_hist.push_front(kp.key_press_raw);
        void'(raw_hist.pop_back());
        all_diff = 1'b1;
        for (int k = 2; k < 2 + DEB; k++) if (raw_hist[k] == deb_level) all_diff = 1'b0;
        pe_now = 1'b0;
        if (all_diff) begin
            deb_level = ~deb_level;
            pe_now    = deb_level;
        end
        pe_prev = pe_now;
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) model_reset();
        else          model_step();
    end

    // ---------------- compare / monitor ----------------
    int     mon_ready = 0;
    int     mon_to    = 0;
    int     mon_pair  = 0;
    digit_t watch_d1  = 2'b01;
    digit_t watch_d2  = 2'b10;

    always @(negedge clk) begin : cmp
        logic [3:0] got;
        check("digit_1", kp.passcode_digit_1, exp_d1);
        check("digit_2", kp.passcode_digit_2, exp_d2);
        check("code_ready", kp.code_ready, exp_ready);
        check("entry_timeout", kp.entry_timeout, exp_to);
        check("digit_count", kp.digit_count, exp_cnt);
        if (kp.code_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_ready", 8'd1, 8'd0);
            end else begin
                got = exp_q.pop_front();
                check("sb_pair", {kp.passcode_digit_1, kp.passcode_digit_2}, got);
            end
        end
        if (kp.code_ready === 1'b1)    mon_ready++;
        if (kp.entry_timeout === 1'b1) mon_to++;
        if (kp.passcode_digit_1 == watch_d1 && kp.passcode_digit_2 == watch_d2) mon_pair++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic mon_clear(input digit_t w1, input digit_t w2);
        watch_d1  = w1;
        watch_d2  = w2;
        mon_ready = 0;
        mon_to    = 0;
        mon_pair  = 0;
    endtask

    task automatic press_key(input digit_t code, input int hold, input int rel);
        @(negedge clk);
        kp.key_code      = code;
        kp.key_press_raw = 1'b1;
        tick(hold);
        kp.key_press_raw = 1'b0;
        tick(rel);
    endtask

    task automatic pulse_clear();
        kp.clear_key = 1'b1;
        tick(1);
        kp.clear_key = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (kp.code_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(name, 8'(kp.code_ready), 8'd1);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("rst_async_d1", kp.passcode_digit_1, 8'h0);
        check("rst_async_d2", kp.passcode_digit_2, 8'h0);
        check("rst_async_cnt", kp.digit_count, 8'h0);
        @(posedge clk);
        #2 reset_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        kp.key_press_raw = 1'b0;
        kp.key_code      = 2'b00;
        kp.clear_key     = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        check("reset_d1", kp.passcode_digit_1, 8'h0);
        check("reset_cnt", kp.digit_count, 8'h0);
        check("reset_state", 8'(kp.fsm_state), 8'(ST_EMPTY));
        tick(2);

        // Clean entry 01 then 10.
        mon_clear(2'b01, 2'b10);
        press_key(2'b01, 6, 8);
        press_key(2'b10, 6, 8);
        tick(20);
        check("clean_ready_pulses", 8'(mon_ready), 8'd1);
        check("clean_hold_cycles", 8'(mon_pair), 8'd8);
        check("clean_count_after", kp.digit_count, 8'd0);

        // Bounce 1-0-1-0 then a steady press: count moves one cycle after press_evt.
        mon_clear(2'b01, 2'b10);
        @(negedge clk);
        kp.key_code = 2'b01;
        kp.key_press_raw = 1'b1; tick(1);
        kp.key_press_raw = 1'b0; tick(1);
        kp.key_press_raw = 1'b1; tick(1);
        kp.key_press_raw = 1'b0; tick(1);
        kp.key_press_raw = 1'b1; tick(6);
        check("bounce_before_evt", kp.digit_count, 8'd0);
        tick(1);
        check("bounce_after_evt", kp.digit_count, 8'd1);
        tick(3);
        kp.key_press_raw = 1'b0;
        tick(8);
        check("bounce_one_digit", kp.digit_count, 8'd1);
        pulse_clear();
        check("clear_one_count", kp.digit_count, 8'd0);
        check("clear_one_state", 8'(kp.fsm_state), 8'(ST_EMPTY));
        tick(4);

        // Timeout, then a fresh 10/01 entry.
        mon_clear(2'b10, 2'b01);
        press_key(2'b01, 6, 6);
        tick(30);
        check("timeout_pulses", 8'(mon_to), 8'd1);
        check("timeout_count", kp.digit_count, 8'd0);
        press_key(2'b10, 6, 8);
        press_key(2'b01, 6, 8);
        tick(20);
        check("after_timeout_pair", 8'(mon_pair), 8'd8);
        check("after_timeout_ready", 8'(mon_ready), 8'd1);

        // Second press_evt lands in the last cycle before timeout: press wins.
        mon_clear(2'b01, 2'b10);
        @(negedge clk);
        kp.key_code = 2'b01; kp.key_press_raw = 1'b1; tick(6);
        kp.key_press_raw = 1'b0; tick(14);
        kp.key_code = 2'b10; kp.key_press_raw = 1'b1; tick(6);
        kp.key_press_raw = 1'b0; tick(20);
        check("collide_no_timeout", 8'(mon_to), 8'd0);
        check("collide_ready", 8'(mon_ready), 8'd1);
        check("collide_pair", 8'(mon_pair), 8'd8);

        // One cycle later: timeout fires first, the press starts a new entry.
        mon_clear(2'b01, 2'b10);
        @(negedge clk);
        kp.key_code = 2'b01; kp.key_press_raw = 1'b1; tick(6);
        kp.key_press_raw = 1'b0; tick(15);
        kp.key_code = 2'b10; kp.key_press_raw = 1'b1; tick(6);
        kp.key_press_raw = 1'b0; tick(6);
        check("late_timeout", 8'(mon_to), 8'd1);
        check("late_no_ready", 8'(mon_ready), 8'd0);
        check("late_new_digit", kp.digit_count, 8'd1);
        pulse_clear();
        tick(4);

        // clear_key coincident with the second press_evt in ONE drops the press.
        mon_clear(2'b01, 2'b10);
        @(negedge clk);
        kp.key_code = 2'b01; kp.key_press_raw = 1'b1; tick(6);
        kp.key_press_raw = 1'b0; tick(4);
        kp.key_code = 2'b10; kp.key_press_raw = 1'b1; tick(6);
        pulse_clear();
        check("clear_coincident_cnt", kp.digit_count, 8'd0);
        tick(2);
        kp.key_press_raw = 1'b0;
        tick(20);
        check("clear_coincident_ready", 8'(mon_ready), 8'd0);
        check("clear_coincident_to", 8'(mon_to), 8'd0);
        check("clear_coincident_idle", kp.digit_count, 8'd0);

        // clear_key during PRESENT.
        mon_clear(2'b01, 2'b10);
        press_key(2'b01, 6, 8);
        press_key(2'b10, 6, 0);
        wait_ready("clear_present_wait");
        tick(3);
        pulse_clear();
        check("clear_present_d1", kp.passcode_digit_1, 8'h0);
        check("clear_present_cnt", kp.digit_count, 8'd0);
        tick(15);
        check("clear_present_pair", 8'(mon_pair), 8'd4);
        check("clear_present_ready", 8'(mon_ready), 8'd1);

        // Asynchronous reset mid-PRESENT, then a new entry.
        press_key(2'b01, 6, 8);
        press_key(2'b10, 6, 0);
        wait_ready("reset_present_wait");
        tick(2);
        pulse_reset();
        tick(4);
        mon_clear(2'b10, 2'b10);
        press_key(2'b10, 6, 8);
        press_key(2'b10, 6, 8);
        tick(20);
        check("post_reset_pair", 8'(mon_pair), 8'd8);
        check("post_reset_ready", 8'(mon_ready), 8'd1);

        // Randomized keypad activity with bounce, short taps, long gaps and aborts.
        for (int t = 0; t < 40; t++) begin
            int nb;
            int hold;
            @(negedge clk);
            kp.key_code = 2'($urandom_range(0, 3));
            nb = $urandom_range(0, 3);
            for (int b = 0; b < nb; b++) begin
                kp.key_press_raw = 1'b1;
                tick($urandom_range(1, 3));
                kp.key_press_raw = 1'b0;
                tick($urandom_range(1, 2));
            end
            kp.key_press_raw = 1'b1;
            hold = $urandom_range(2, 10);
            for (int h = 0; h < hold; h++) begin
                kp.clear_key = ($urandom_range(0, 19) == 0);
                tick(1);
            end
            kp.clear_key     = 1'b0;
            kp.key_press_raw = 1'b0;
            tick($urandom_range(3, 30));
        end
        tick(30);
        check("sb_drain", 8'(exp_q.size()), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
